// File: rtl/pipe_pkg.sv
// Shared decode-stage constants: instruction codes, "no register" ID, E-stage bubble value.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  localparam logic [3:0] ID_NONE = 4'hF;

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // Control half of the E pipeline register; the data half is all-zero in a bubble.
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] srca;
    logic [3:0] srcb;
    logic [3:0] dste;
    logic [3:0] dstm;
  } e_ctl_t;

  localparam e_ctl_t E_CTL_BUBBLE = '{
    icode: I_NOP,
    ifun:  4'h0,
    srca:  ID_NONE,
    srcb:  ID_NONE,
    dste:  ID_NONE,
    dstm:  ID_NONE
  };

  // Register IDs outside the implemented file collapse to "no register".
  function automatic logic [3:0] reg_id_clean(input logic [3:0] id, input int nreg);
    return (32'(id) < 32'(nreg)) ? id : ID_NONE;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// Architectural register file: two combinational read ports, two write ports (M port wins on collision).
// Latency: reads are combinational; writes land on the rising clk edge.
// Backpressure: none; both write ports are accepted every cycle, suppressed only by rst.
module pipe_regfile import pipe_pkg::*; #(
  parameter int WORD_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        wr_e_id,
  input  logic [WORD_W-1:0] wr_e_val,
  input  logic [3:0]        wr_m_id,
  input  logic [WORD_W-1:0] wr_m_val,
  input  logic [3:0]        rd_a_id,
  output logic [WORD_W-1:0] rd_a_val,
  input  logic [3:0]        rd_b_id,
  output logic [WORD_W-1:0] rd_b_val
);

  logic [WORD_W-1:0] regs [NREG];

  // Clear on reset; otherwise apply E then M writes so M takes precedence on the same ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_e_id == 4'(i)) regs[i] <= wr_e_val;
        if (wr_m_id == 4'(i)) regs[i] <= wr_m_val;
      end
    end
  end

  // Read ports: IDs with no backing register (including ID_NONE) read as zero.
  always_comb begin
    rd_a_val = '0;
    rd_b_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_a_id == 4'(i)) rd_a_val = regs[i];
      if (rd_b_id == 4'(i)) rd_b_val = regs[i];
    end
  end

endmodule

// File: rtl/pipe_decode_stage.sv
// Decode stage: source/destination selection, register read with forwarding, E pipeline register.
// Latency: 1 cycle from D fields to E outputs; d_srcA/d_srcB are combinational.
// Backpressure: E_stall holds the E register, E_bubble injects a NOP; rst overrides both.
module pipe_decode_stage import pipe_pkg::*; #(
  parameter int WORD_W = 64,
  parameter int NREG   = 15,
  parameter int RSP_ID = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [WORD_W-1:0] D_valC,
  input  logic [WORD_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [WORD_W-1:0] e_valE,
  input  logic [3:0]        M_dstM,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [3:0]        M_dstE,
  input  logic [WORD_W-1:0] M_valE,
  input  logic [3:0]        W_dstM,
  input  logic [WORD_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [WORD_W-1:0] W_valE,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [WORD_W-1:0] E_valC,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB
);

  localparam logic [3:0] RSP = 4'(RSP_ID);

  logic [3:0]        ra, rb;
  logic [3:0]        d_dste, d_dstm;
  logic [WORD_W-1:0] rf_a, rf_b;
  logic [WORD_W-1:0] d_vala, d_valb;

  e_ctl_t            e_ctl_q;
  logic [WORD_W-1:0] e_valc_q, e_vala_q, e_valb_q;

  // Youngest producer wins; ID_NONE never matches so unused sources fall through to the file (which reads 0).
  function automatic logic [WORD_W-1:0] fwd_sel(
    input logic [3:0]        src,
    input logic [WORD_W-1:0] rf_val,
    input logic [3:0]        ex_id,  input logic [WORD_W-1:0] ex_val,
    input logic [3:0]        mm_id,  input logic [WORD_W-1:0] mm_val,
    input logic [3:0]        me_id,  input logic [WORD_W-1:0] me_val,
    input logic [3:0]        wm_id,  input logic [WORD_W-1:0] wm_val,
    input logic [3:0]        we_id,  input logic [WORD_W-1:0] we_val
  );
    if (src == ID_NONE)     return rf_val;
    else if (src == ex_id)  return ex_val;
    else if (src == mm_id)  return mm_val;
    else if (src == me_id)  return me_val;
    else if (src == wm_id)  return wm_val;
    else if (src == we_id)  return we_val;
    else                    return rf_val;
  endfunction

  assign ra = reg_id_clean(D_rA, NREG);
  assign rb = reg_id_clean(D_rB, NREG);

  // Per-icode source/destination selection; anything not named stays ID_NONE.
  always_comb begin
    d_srcA = ID_NONE;
    d_srcB = ID_NONE;
    d_dste = ID_NONE;
    d_dstm = ID_NONE;
    case (D_icode)
      I_CMOV:  begin d_srcA = ra;  d_dste = rb; end
      I_IRMOV: begin d_dste = rb; end
      I_RMMOV: begin d_srcA = ra;  d_srcB = rb; end
      I_MRMOV: begin d_srcB = rb;  d_dstm = ra; end
      I_OPQ:   begin d_srcA = ra;  d_srcB = rb;  d_dste = rb; end
      I_CALL:  begin d_srcB = RSP; d_dste = RSP; end
      I_RET:   begin d_srcA = RSP; d_srcB = RSP; d_dste = RSP; end
      I_PUSH:  begin d_srcA = ra;  d_srcB = RSP; d_dste = RSP; end
      I_POP:   begin d_srcA = RSP; d_srcB = RSP; d_dste = RSP; d_dstm = ra; end
      default: ;
    endcase
  end

  pipe_regfile #(
    .WORD_W (WORD_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_e_id  (W_dstE),
    .wr_e_val (W_valE),
    .wr_m_id  (W_dstM),
    .wr_m_val (W_valM),
    .rd_a_id  (d_srcA),
    .rd_a_val (rf_a),
    .rd_b_id  (d_srcB),
    .rd_b_val (rf_b)
  );

  // Operand selection: jumps and calls carry valP in valA; otherwise forward or read the file.
  always_comb begin
    d_vala = fwd_sel(d_srcA, rf_a, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    if (D_icode == I_JXX || D_icode == I_CALL) d_vala = D_valP;
    d_valb = fwd_sel(d_srcB, rf_b, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
  end

  // E pipeline register: reset and bubble both load a NOP, stall holds, otherwise load decode results.
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      e_ctl_q  <= E_CTL_BUBBLE;
      e_valc_q <= '0;
      e_vala_q <= '0;
      e_valb_q <= '0;
    end else if (!E_stall) begin
      e_ctl_q  <= '{icode: D_icode, ifun: D_ifun, srca: d_srcA,
                    srcb: d_srcB, dste: d_dste, dstm: d_dstm};
      e_valc_q <= D_valC;
      e_vala_q <= d_vala;
      e_valb_q <= d_valb;
    end
  end

  assign E_icode = e_ctl_q.icode;
  assign E_ifun  = e_ctl_q.ifun;
  assign E_srcA  = e_ctl_q.srca;
  assign E_srcB  = e_ctl_q.srcb;
  assign E_dstE  = e_ctl_q.dste;
  assign E_dstM  = e_ctl_q.dstm;
  assign E_valC  = e_valc_q;
  assign E_valA  = e_vala_q;
  assign E_valB  = e_valb_q;

endmodule

// File: tb/tb_pipe_decode_stage.sv
module tb_pipe_decode_stage;

  localparam int W = 64;
  localparam logic [23:0] BUB = 24'h10FFFF;

  logic         clk = 1'b0;
  logic         rst, E_stall, E_bubble;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic [3:0]   e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [3:0]   d_srcA, d_srcB;
  logic [3:0]   E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [W-1:0] E_valC, E_valA, E_valB;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_decode_stage #(.WORD_W(W), .NREG(15), .RSP_ID(4)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .M_dstE(M_dstE), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
  );

  typedef struct {
    logic        rst, stall, bubble;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [3:0]  e_dst;  logic [63:0] e_val;
    logic [3:0]  mm_dst; logic [63:0] mm_val;
    logic [3:0]  me_dst; logic [63:0] me_val;
    logic [3:0]  wm_dst; logic [63:0] wm_val;
    logic [3:0]  we_dst; logic [63:0] we_val;
    logic [23:0] x_ids;  // {icode, ifun, srcA, srcB, dstE, dstM}
    logic [63:0] x_valc, x_vala, x_valb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t op(logic [3:0] icode, logic [3:0] ra, logic [3:0] rb);
    vec_t v;
    v.rst = 0; v.stall = 0; v.bubble = 0;
    v.icode = icode; v.ifun = 0; v.ra = ra; v.rb = rb;
    v.valc = 0; v.valp = 0;
    v.e_dst = 4'hF;  v.e_val = 0;
    v.mm_dst = 4'hF; v.mm_val = 0;
    v.me_dst = 4'hF; v.me_val = 0;
    v.wm_dst = 4'hF; v.wm_val = 0;
    v.we_dst = 4'hF; v.we_val = 0;
    v.x_ids = BUB; v.x_valc = 0; v.x_vala = 0; v.x_valb = 0;
    return v;
  endfunction

  function automatic vec_t ex(vec_t v, logic [23:0] ids, logic [63:0] vc, logic [63:0] va, logic [63:0] vb);
    vec_t r = v;
    r.x_ids = ids; r.x_valc = vc; r.x_vala = va; r.x_valb = vb;
    return r;
  endfunction

  task automatic apply(vec_t v);
    rst = v.rst; E_stall = v.stall; E_bubble = v.bubble;
    D_icode = v.icode; D_ifun = v.ifun; D_rA = v.ra; D_rB = v.rb;
    D_valC = v.valc; D_valP = v.valp;
    e_dstE = v.e_dst;  e_valE = v.e_val;
    M_dstM = v.mm_dst; m_valM = v.mm_val;
    M_dstE = v.me_dst; M_valE = v.me_val;
    W_dstM = v.wm_dst; W_valM = v.wm_val;
    W_dstE = v.we_dst; W_valE = v.we_val;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  string       roles [16];          // chars: srcA srcB dstE dstM; A=rA B=rB S=stack '-'=none
  logic [63:0] mreg  [15];
  logic [23:0] m_ids;
  logic [63:0] m_valc, m_vala, m_valb;

  function automatic logic [3:0] pick(byte c, logic [3:0] ra, logic [3:0] rb);
    if (c == "A") return ra;
    if (c == "B") return rb;
    if (c == "S") return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [63:0] operand(logic [3:0] src);
    logic [3:0]  fid [5];
    logic [63:0] fv  [5];
    fid[0] = e_dstE; fv[0] = e_valE;
    fid[1] = M_dstM; fv[1] = m_valM;
    fid[2] = M_dstE; fv[2] = M_valE;
    fid[3] = W_dstM; fv[3] = W_valM;
    fid[4] = W_dstE; fv[4] = W_valE;
    if (src == 4'hF) return 64'd0;
    for (int k = 0; k < 5; k++) if (fid[k] == src) return fv[k];
    return mreg[src];
  endfunction

  // Evaluates the current inputs as one clock edge; returns the expected combinational sources.
  task automatic model_edge(output logic [3:0] sa, output logic [3:0] sb);
    string r;
    logic [3:0] de, dm;
    logic [63:0] va, vb;
    r  = roles[D_icode];
    sa = pick(r[0], D_rA, D_rB);
    sb = pick(r[1], D_rA, D_rB);
    de = pick(r[2], D_rA, D_rB);
    dm = pick(r[3], D_rA, D_rB);
    va = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : operand(sa);
    vb = operand(sb);
    if (rst) begin
      m_ids = BUB; m_valc = 0; m_vala = 0; m_valb = 0;
      for (int k = 0; k < 15; k++) mreg[k] = 0;
    end else begin
      if (E_bubble) begin
        m_ids = BUB; m_valc = 0; m_vala = 0; m_valb = 0;
      end else if (!E_stall) begin
        m_ids = {D_icode, D_ifun, sa, sb, de, dm};
        m_valc = D_valC; m_vala = va; m_valb = vb;
      end
      if (W_dstE != 4'hF) mreg[W_dstE] = W_valE;
      if (W_dstM != 4'hF) mreg[W_dstM] = W_valM;
    end
  endtask

  function automatic logic [3:0] rid();
    int unsigned x = $urandom_range(0, 9);
    return (x >= 8) ? 4'hF : 4'(x);
  endfunction

  initial begin
    vec_t v;
    logic [3:0] xsa, xsb;

    for (int k = 0; k < 16; k++) roles[k] = "----";
    roles[2]  = "A-B-"; roles[3]  = "--B-"; roles[4]  = "AB--"; roles[5]  = "-B-A";
    roles[6]  = "ABB-"; roles[8]  = "-SS-"; roles[9]  = "SSS-"; roles[10] = "ASS-";
    roles[11] = "SSSA";

    // ---- directed table ----
    v = op(6, 2, 3); v.rst = 1; v.we_dst = 2; v.we_val = 'h99;   vecs.push_back(v);
    v = op(6, 2, 3); v.rst = 1;                                  vecs.push_back(v);
    v = op(6, 2, 3);                                             vecs.push_back(ex(v, 24'h60233F, 0, 0, 0));
    v = op(6, 2, 3); v.ifun = 2; v.we_dst = 2; v.we_val = 'h55;  vecs.push_back(ex(v, 24'h62233F, 0, 'h55, 0));
    v = op(6, 2, 3);                                             vecs.push_back(ex(v, 24'h60233F, 0, 'h55, 0));
    v = op(4, 5, 2); v.e_dst = 5; v.e_val = 'h11; v.me_dst = 5; v.me_val = 'h22; v.we_dst = 5; v.we_val = 'h33;
    vecs.push_back(ex(v, 24'h4052FF, 0, 'h11, 'h55));
    v = op(4, 5, 2); v.me_dst = 5; v.me_val = 'h22; v.we_dst = 5; v.we_val = 'h33;
    vecs.push_back(ex(v, 24'h4052FF, 0, 'h22, 'h55));
    v = op(4, 5, 2); v.mm_dst = 5; v.mm_val = 'h44; v.me_dst = 5; v.me_val = 'h22;
    vecs.push_back(ex(v, 24'h4052FF, 0, 'h44, 'h55));
    v = op(4, 5, 2); v.wm_dst = 5; v.wm_val = 'h66; v.we_dst = 5; v.we_val = 'h77;
    vecs.push_back(ex(v, 24'h4052FF, 0, 'h66, 'h55));
    v = op(6, 5, 5);                                             vecs.push_back(ex(v, 24'h60555F, 0, 'h66, 'h66));
    v = op(8, 4'hF, 4'hF); v.valp = 'h40; v.valc = 'h1234; v.e_dst = 4; v.e_val = 'h99;
    vecs.push_back(ex(v, 24'h80F44F, 'h1234, 'h40, 'h99));
    v = op(1, 4'hF, 4'hF); v.wm_dst = 6; v.wm_val = 2; v.we_dst = 6; v.we_val = 1;
    vecs.push_back(v);
    v = op(6, 6, 6);                                             vecs.push_back(ex(v, 24'h60666F, 0, 2, 2));
    v = op(5, 7, 2); v.valc = 'hABCD;                            vecs.push_back(ex(v, 24'h50F2F7, 'hABCD, 0, 'h55));
    v = op(6, 6, 6); v.stall = 1;                                vecs.push_back(ex(v, 24'h50F2F7, 'hABCD, 0, 'h55));
    v = op(6, 6, 6); v.stall = 1;                                vecs.push_back(ex(v, 24'h50F2F7, 'hABCD, 0, 'h55));
    v = op(6, 6, 6); v.stall = 1; v.bubble = 1;                  vecs.push_back(v);
    v = op(10, 6, 4'hF);                                         vecs.push_back(ex(v, 24'hA0644F, 0, 2, 0));
    v = op(6, 6, 6); v.stall = 1; v.rst = 1; v.we_dst = 3; v.we_val = 9;
    vecs.push_back(v);
    v = op(6, 6, 2);                                             vecs.push_back(ex(v, 24'h60622F, 0, 0, 0));
    v = op(6, 3, 5);                                             vecs.push_back(ex(v, 24'h60355F, 0, 0, 0));
    v = op(2, 4'hF, 3); v.e_val = 'h77; v.we_val = 5;            vecs.push_back(ex(v, 24'h20FF3F, 0, 0, 0));
    v = op(11, 1, 4'hF);                                         vecs.push_back(ex(v, 24'hB04441, 0, 0, 0));
    v = op(7, 4'hF, 4'hF); v.valp = 'h88;                        vecs.push_back(ex(v, 24'h70FFFF, 0, 'h88, 0));
    v = op(9, 3, 3);                                             vecs.push_back(ex(v, 24'h90444F, 0, 0, 0));
    v = op(3, 1, 9); v.valc = 5;                                 vecs.push_back(ex(v, 24'h30FF9F, 5, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d ids", i), 64'({E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM}), 64'(vecs[i].x_ids));
      check($sformatf("vec%0d valC", i), E_valC, vecs[i].x_valc);
      check($sformatf("vec%0d valA", i), E_valA, vecs[i].x_vala);
      check($sformatf("vec%0d valB", i), E_valB, vecs[i].x_valb);
    end

    // ---- randomized against the model ----
    apply(op(1, 4'hF, 4'hF)); rst = 1;
    model_edge(xsa, xsb);
    @(posedge clk); #1;
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 7) == 0);
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA = rid(); D_rB = rid();
      D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
      e_dstE = rid(); e_valE = {$urandom, $urandom};
      M_dstM = rid(); m_valM = {$urandom, $urandom};
      M_dstE = rid(); M_valE = {$urandom, $urandom};
      W_dstM = rid(); W_valM = {$urandom, $urandom};
      W_dstE = rid(); W_valE = {$urandom, $urandom};
      #1;
      model_edge(xsa, xsb);
      check($sformatf("rnd%0d d_src", c), 64'({d_srcA, d_srcB}), 64'({xsa, xsb}));
      @(posedge clk); #1;
      check($sformatf("rnd%0d ids", c), 64'({E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM}), 64'(m_ids));
      check($sformatf("rnd%0d valA", c), E_valA, m_vala);
      check($sformatf("rnd%0d valB", c), E_valB, m_valb);
      check($sformatf("rnd%0d valC", c), E_valC, m_valc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
